// File: rtl/audio_bram_pkg.sv
// Shared types and constants for the sample-BRAM port B arbiter.
package audio_bram_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        R0   = 2'd1,
        R1   = 2'd2
    } owner_e;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 8;
    localparam int BRAM_BYTE_SHIFT = 2;

    function automatic logic [31:0] byte_addr(input logic [31:0] word_idx);
        return word_idx << BRAM_BYTE_SHIFT;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bram_rd_return_pipe.sv
// Delay line of {valid, id} matching the BRAM read latency; steers each
// returned word to the requester that issued the read.
module bram_rd_return_pipe #(
    parameter int READ_LATENCY = 1,
    parameter int DATA_W       = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_id,
    input  logic [DATA_W-1:0] i_dout,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata
);

    logic [READ_LATENCY-1:0] r_valid;
    logic [READ_LATENCY-1:0] r_id;
    logic                    w_tail_valid;
    logic                    w_tail_id;

    // Shift the issue record along; reset drops every in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= {READ_LATENCY{1'b0}};
            r_id    <= {READ_LATENCY{1'b0}};
        end else begin
            r_valid[0] <= i_valid;
            r_id[0]    <= i_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_id[i]    <= r_id[i-1];
            end
        end
    end

    assign w_tail_valid = r_valid[READ_LATENCY-1];
    assign w_tail_id    = r_id[READ_LATENCY-1];
    assign o_rvalid0    = w_tail_valid && !w_tail_id;
    assign o_rvalid1    = w_tail_valid && w_tail_id;
    assign o_rdata      = w_tail_valid ? i_dout : {DATA_W{1'b0}};

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin, per-beat arbiter for BRAM port B with capped locked bursts.
// Optional statistics outputs are enabled by defining BRAM_ARB_STATS_EN.
module bram_port_arbiter
    import audio_bram_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [31:0]       BRAM_addr,
    output logic              BRAM_clk,
    output logic              BRAM_en,
    output logic              BRAM_rst,
    output logic [3:0]        BRAM_we,
    output logic [31:0]       BRAM_din,
    input  logic [31:0]       BRAM_dout
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [15:0]       stat_wait_max
`endif
);

    localparam int               CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    owner_e           r_own;
    owner_e           r_last;
    owner_e           w_other;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [31:0]      r_addr_hold;
    logic [31:0]      w_gnt_addr;
    logic             w_req_own;
    logic             w_req_oth;
    logic             w_lock_own;
    logic             w_any_gnt;

    // View the request lines relative to the current owner.
    always_comb begin
        w_req_own  = 1'b0;
        w_req_oth  = 1'b0;
        w_lock_own = 1'b0;
        w_other    = R0;
        case (r_own)
            R0: begin
                w_req_own  = req0;
                w_req_oth  = req1;
                w_lock_own = lock0;
                w_other    = R1;
            end
            R1: begin
                w_req_own  = req1;
                w_req_oth  = req0;
                w_lock_own = lock1;
                w_other    = R0;
            end
            default: begin
                w_req_own  = 1'b0;
                w_req_oth  = 1'b0;
                w_lock_own = 1'b0;
                w_other    = R0;
            end
        endcase
    end

    assign gnt0       = req0 && (r_own == R0);
    assign gnt1       = req1 && (r_own == R1);
    assign w_any_gnt  = gnt0 || gnt1;
    assign w_gnt_addr = byte_addr(32'(gnt1 ? addr1 : addr0));
    assign BRAM_en    = w_any_gnt;
    assign BRAM_addr  = w_any_gnt ? w_gnt_addr : r_addr_hold;
    assign BRAM_clk   = clk;
    assign BRAM_rst   = rst;
    assign BRAM_we    = 4'h0;
    assign BRAM_din   = 32'h0000_0000;

    // Ownership FSM; the handover is decided during the granted beat so the next owner is served without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_own      <= NONE;
            r_last     <= R1;
            r_beat_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_own)
                NONE: begin
                    r_beat_cnt <= {CNT_W{1'b0}};
                    if (req0 && req1) begin
                        r_own <= (r_last == R0) ? R1 : R0;
                    end else if (req0) begin
                        r_own <= R0;
                    end else if (req1) begin
                        r_own <= R1;
                    end else begin
                        r_own <= NONE;
                    end
                end
                R0, R1: begin
                    if (!w_req_own) begin
                        r_own      <= w_req_oth ? w_other : NONE;
                        r_beat_cnt <= {CNT_W{1'b0}};
                    end else if (w_req_oth && (!w_lock_own || (r_beat_cnt == CNT_MAX))) begin
                        r_own      <= w_other;
                        r_last     <= r_own;
                        r_beat_cnt <= {CNT_W{1'b0}};
                    end else if (r_beat_cnt != CNT_MAX) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end else begin
                        r_beat_cnt <= r_beat_cnt;
                    end
                end
                default: begin
                    r_own      <= NONE;
                    r_beat_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // BRAM_addr keeps the last issued address while no beat is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_hold <= 32'h0000_0000;
        end else if (w_any_gnt) begin
            r_addr_hold <= w_gnt_addr;
        end else begin
            r_addr_hold <= r_addr_hold;
        end
    end

    bram_rd_return_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (DATA_W)
    ) u_ret (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (w_any_gnt),
        .i_id      (gnt1),
        .i_dout    (BRAM_dout[DATA_W-1:0]),
        .o_rvalid0 (rvalid0),
        .o_rvalid1 (rvalid1),
        .o_rdata   (rdata)
    );

`ifdef BRAM_ARB_STATS_EN
    logic [15:0] r_wait0;
    logic [15:0] r_wait1;
    logic [15:0] w_wait0_nxt;
    logic [15:0] w_wait1_nxt;
    logic [15:0] w_wait_peak;

    // Length of each requester's current stall, including this cycle.
    always_comb begin
        w_wait0_nxt = (req0 && !gnt0) ? sat_inc16(r_wait0) : 16'd0;
        w_wait1_nxt = (req1 && !gnt1) ? sat_inc16(r_wait1) : 16'd0;
        if (w_wait0_nxt > w_wait1_nxt) begin
            w_wait_peak = w_wait0_nxt;
        end else begin
            w_wait_peak = w_wait1_nxt;
        end
    end

    // Grant counters wrap; the stall maximum saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_gnt0     <= 32'd0;
            stat_gnt1     <= 32'd0;
            stat_wait_max <= 16'd0;
            r_wait0       <= 16'd0;
            r_wait1       <= 16'd0;
        end else begin
            stat_gnt0     <= gnt0 ? stat_gnt0 + 32'd1 : stat_gnt0;
            stat_gnt1     <= gnt1 ? stat_gnt1 + 32'd1 : stat_gnt1;
            stat_wait_max <= (w_wait_peak > stat_wait_max) ? w_wait_peak : stat_wait_max;
            r_wait0       <= w_wait0_nxt;
            r_wait1       <= w_wait1_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: three instances (READ_LATENCY 1..3, MAX_BURST 4)
// share stimulus; a behavioural model checks every cycle, plus directed tables.
module tb_bram_port_arbiter;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, req1, lock0, lock1;
    logic [7:0] addr0, addr1;

    logic [2:0]       gnt0_v, gnt1_v, rv0_v, rv1_v, bclk_v, ben_v, brst_v;
    logic [2:0][31:0] rdata_v, baddr_v, bdin_v, bdout_v;
    logic [2:0][3:0]  bwe_v;
`ifdef BRAM_ARB_STATS_EN
    logic [2:0][31:0] sg0_v, sg1_v;
    logic [2:0][15:0] swm_v;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [31:0] memf(input logic [7:0] w);
        return {~w, w, 8'h5A, w ^ 8'hC3};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        logic [31:0] stg [3];
        // BRAM model: read data emerges g+1 edges after an enabled cycle.
        always @(posedge clk) begin
            if (ben_v[g]) stg[0] <= memf(baddr_v[g][9:2]);
            stg[1] <= stg[0];
            stg[2] <= stg[1];
        end
        assign bdout_v[g] = stg[g];

        bram_port_arbiter #(
            .ADDR_W(8), .DATA_W(32), .READ_LATENCY(g + 1), .MAX_BURST(MAXB)
        ) u_dut (
            .clk(clk), .rst(rst),
            .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
            .addr0(addr0), .addr1(addr1),
            .gnt0(gnt0_v[g]), .gnt1(gnt1_v[g]),
            .rvalid0(rv0_v[g]), .rvalid1(rv1_v[g]), .rdata(rdata_v[g]),
            .BRAM_addr(baddr_v[g]), .BRAM_clk(bclk_v[g]), .BRAM_en(ben_v[g]),
            .BRAM_rst(brst_v[g]), .BRAM_we(bwe_v[g]), .BRAM_din(bdin_v[g]),
            .BRAM_dout(bdout_v[g])
`ifdef BRAM_ARB_STATS_EN
            , .stat_gnt0(sg0_v[g]), .stat_gnt1(sg1_v[g]), .stat_wait_max(swm_v[g])
`endif
        );
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic        id;
        logic [31:0] d;
    } ret_t;

    ret_t        m_ring [3][4];
    int          m_owner;   // -1 idle, else index of requester holding the port
    int          m_last;
    int          m_tenure;  // beats served in the current tenure
    int          m_cyc;
    logic [31:0] m_hold;
    int          m_sg0, m_sg1, m_run0, m_run1, m_wmax;

    task automatic mreset();
        m_owner = -1; m_last = 1; m_tenure = 0; m_cyc = 0; m_hold = 32'd0;
        m_sg0 = 0; m_sg1 = 0; m_run0 = 0; m_run1 = 0; m_wmax = 0;
        for (int g = 0; g < 3; g++)
            for (int s = 0; s < 4; s++) m_ring[g][s] = '0;
    endtask

    initial begin : monitor
        logic        eg0, eg1;
        logic [31:0] exp_addr;
        ret_t        rt;
        int          o, k, j;
        logic        rk, rj, lk;
        mreset();
        forever begin
            @(negedge clk);
            if (rst) mreset();
            eg0 = req0 && (m_owner == 0);
            eg1 = req1 && (m_owner == 1);
            exp_addr = eg0 ? {22'd0, addr0, 2'b00} : (eg1 ? {22'd0, addr1, 2'b00} : m_hold);
            for (int g = 0; g < 3; g++) begin
                rt = m_ring[g][m_cyc % 4];
                chk($sformatf("gnt0_L%0d", g + 1), 64'(gnt0_v[g]), 64'(eg0));
                chk($sformatf("gnt1_L%0d", g + 1), 64'(gnt1_v[g]), 64'(eg1));
                chk($sformatf("en_L%0d", g + 1), 64'(ben_v[g]), 64'(eg0 | eg1));
                chk($sformatf("addr_L%0d", g + 1), 64'(baddr_v[g]), 64'(exp_addr));
                chk($sformatf("rvalid0_L%0d", g + 1), 64'(rv0_v[g]), 64'(rt.v && !rt.id));
                chk($sformatf("rvalid1_L%0d", g + 1), 64'(rv1_v[g]), 64'(rt.v && rt.id));
                if (rt.v) chk($sformatf("rdata_L%0d", g + 1), 64'(rdata_v[g]), 64'(rt.d));
                chk($sformatf("we_din_L%0d", g + 1), {28'd0, bwe_v[g], bdin_v[g]}, 64'd0);
                chk($sformatf("clk_rst_L%0d", g + 1), {62'd0, bclk_v[g], brst_v[g]}, {62'd0, clk, rst});
`ifdef BRAM_ARB_STATS_EN
                chk($sformatf("stat_gnt0_L%0d", g + 1), 64'(sg0_v[g]), 64'(m_sg0));
                chk($sformatf("stat_gnt1_L%0d", g + 1), 64'(sg1_v[g]), 64'(m_sg1));
                chk($sformatf("stat_wmax_L%0d", g + 1), 64'(swm_v[g]), 64'(m_wmax));
`endif
            end
            if (!rst) begin
                for (int g = 0; g < 3; g++) begin
                    m_ring[g][m_cyc % 4] = '0;
                    if (eg0 || eg1)
                        m_ring[g][(m_cyc + g + 1) % 4] = {1'b1, eg1, memf(eg1 ? addr1 : addr0)};
                end
                if (eg0 || eg1) m_hold = exp_addr;
                m_sg0 += int'(eg0);
                m_sg1 += int'(eg1);
                m_run0 = (req0 && !eg0) ? m_run0 + 1 : 0;
                m_run1 = (req1 && !eg1) ? m_run1 + 1 : 0;
                if (m_run0 > m_wmax) m_wmax = m_run0;
                if (m_run1 > m_wmax) m_wmax = m_run1;
                o = m_owner;
                if (o < 0) begin
                    if (req0 && req1) o = 1 - m_last;
                    else if (req0)    o = 0;
                    else if (req1)    o = 1;
                    m_tenure = 0;
                end else begin
                    k  = o;
                    j  = 1 - o;
                    rk = (k == 0) ? req0 : req1;
                    rj = (j == 0) ? req0 : req1;
                    lk = (k == 0) ? lock0 : lock1;
                    if (!rk) begin
                        o = rj ? j : -1;
                        m_tenure = 0;
                    end else if (rj && (!lk || m_tenure >= MAXB - 1)) begin
                        m_last = k;
                        o = j;
                        m_tenure = 0;
                    end else begin
                        m_tenure++;
                    end
                end
                m_owner = o;
                m_cyc++;
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       rst, r0, r1, l0, l1;
        logic [7:0] a0, a1;
        logic       e0, e1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rs, input logic r0, input logic r1, input logic l0,
                       input logic l1, input logic [7:0] a0, input logic [7:0] a1,
                       input logic e0, input logic e1);
        vec_t v;
        v = '{rs, r0, r1, l0, l1, a0, a1, e0, e1};
        tbl.push_back(v);
    endtask

    initial begin : stim
        logic g0p, g1p;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 8'd0; addr1 = 8'd0;

        // single requester from reset
        add(1, 0, 0, 0, 0, 8'd0,  8'd0,  0, 0);
        add(0, 1, 0, 0, 0, 8'd5,  8'd0,  0, 0);
        add(0, 1, 0, 0, 0, 8'd5,  8'd0,  1, 0);
        add(0, 0, 0, 0, 0, 8'd5,  8'd0,  0, 0);
        add(0, 0, 0, 0, 0, 8'd5,  8'd0,  0, 0);
        // tie from reset, unlocked
        add(1, 0, 0, 0, 0, 8'd0,  8'd0,  0, 0);
        add(0, 1, 1, 0, 0, 8'd10, 8'd20, 0, 0);
        add(0, 1, 1, 0, 0, 8'd10, 8'd20, 1, 0);
        add(0, 1, 1, 0, 0, 8'd11, 8'd20, 0, 1);
        add(0, 1, 1, 0, 0, 8'd11, 8'd21, 1, 0);
        add(0, 1, 1, 0, 0, 8'd12, 8'd21, 0, 1);
        add(0, 1, 1, 0, 0, 8'd12, 8'd22, 1, 0);
        add(0, 1, 1, 0, 0, 8'd13, 8'd22, 0, 1);
        add(0, 0, 0, 0, 0, 8'd13, 8'd22, 0, 0);
        // starvation cap: lock0, req1 joins at beat 3
        add(1, 0, 0, 0, 0, 8'd0,  8'd0,  0, 0);
        add(0, 1, 0, 1, 0, 8'd30, 8'd0,  0, 0);
        add(0, 1, 0, 1, 0, 8'd31, 8'd0,  1, 0);
        add(0, 1, 0, 1, 0, 8'd32, 8'd0,  1, 0);
        add(0, 1, 1, 1, 0, 8'd33, 8'd40, 1, 0);
        add(0, 1, 1, 1, 0, 8'd34, 8'd40, 1, 0);
        add(0, 1, 1, 1, 0, 8'd35, 8'd40, 0, 1);
        add(0, 1, 1, 1, 0, 8'd35, 8'd41, 1, 0);
        add(0, 0, 0, 0, 0, 8'd35, 8'd41, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
            lock0 = tbl[i].l0; lock1 = tbl[i].l1; addr0 = tbl[i].a0; addr1 = tbl[i].a1;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt0", i), 64'(gnt0_v[0]), 64'(tbl[i].e0));
            chk($sformatf("tbl%0d_gnt1", i), 64'(gnt1_v[2]), 64'(tbl[i].e1));
            @(posedge clk);
            #1;
        end

        // reset with reads in flight on the latency-3 instance
        rst = 1'b0; req0 = 1'b1; lock0 = 1'b1; req1 = 1'b0; addr0 = 8'd50;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1; req0 = 1'b0; lock0 = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_gnt_L%0d", g + 1), {62'd0, gnt0_v[g], gnt1_v[g]}, 64'd0);
            chk($sformatf("rst_en_addr_L%0d", g + 1), {31'd0, ben_v[g], baddr_v[g]}, 64'd0);
            chk($sformatf("rst_rv_L%0d", g + 1), {30'd0, rv0_v[g], rv1_v[g], rdata_v[g]}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++)
                chk($sformatf("post_rst_rv_L%0d_c%0d", g + 1, c), {62'd0, rv0_v[g], rv1_v[g]}, 64'd0);
        end
        @(posedge clk);
        #1;
        req0 = 1'b1; addr0 = 8'd7;
        @(negedge clk);
        chk("post_rst_arb_cycle", 64'(gnt0_v[1]), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_first_gnt", 64'(gnt0_v[1]), 64'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;

        // randomized traffic; addresses only change once the pending beat is granted
        g0p = 1'b0; g1p = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!req0 || g0p) addr0 = 8'($urandom);
            if (!req1 || g1p) addr1 = 8'($urandom);
            req0  = ($urandom_range(0, 9) < 7);
            req1  = ($urandom_range(0, 9) < 6);
            lock0 = ($urandom_range(0, 1) == 1);
            lock1 = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            @(negedge clk);
            g0p = gnt0_v[0];
            g1p = gnt1_v[0];
            @(posedge clk);
            #1;
        end

`ifdef BRAM_ARB_STATS_EN
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("stat_sum_10", 64'(sg0_v[0] + sg1_v[0]), 64'd10);
        chk("stat_wait_max_2", 64'(swm_v[0]), 64'd2);
`endif

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
